// File: rtl/exmem_copy_master.sv
// Wishbone block-copy initiator: reads up to BUF_DEPTH words into a local buffer,
// writes them to the destination range, and repeats chunkwise until the length is consumed.
module exmem_copy_master #(
   parameter int unsigned BUF_DEPTH = 8,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_src,
   input  logic [31:0]      cmd_dst,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic [31:0]      wbm_dat_i
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TO_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_GAP,
      S_WR_REQ,
      S_WR_GAP
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        src_q, src_d;
   logic [31:0]        dst_q, dst_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   chunk_q, chunk_d;
   logic [CNT_W-1:0]   wptr_q, wptr_d;
   logic [CNT_W-1:0]   rptr_q, rptr_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               stb_q, stb_d;
   logic               we_q, we_d;
   logic [3:0]         sel_q, sel_d;
   logic [31:0]        adr_q, adr_d;
   logic [31:0]        dat_q, dat_d;
   logic               mem_we;
   logic [31:0]        mem_q [BUF_DEPTH];

   // Words in the next chunk: the smaller of what is left and the buffer size.
   function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] rem);
      if (32'(rem) > BUF_DEPTH) return CNT_W'(BUF_DEPTH);
      return CNT_W'(rem);
   endfunction

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      chunk_d = chunk_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      to_d    = to_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            to_d = '0;
            if (cmd_valid) begin
               src_d  = cmd_src & 32'hFFFF_FFFC;
               dst_d  = cmd_dst & 32'hFFFF_FFFC;
               rem_d  = cmd_len;
               wptr_d = '0;
               rptr_d = '0;
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  chunk_d = chunk_of(cmd_len);
                  state_d = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (wbm_ack_i) begin
               mem_we  = 1'b1;
               wptr_d  = wptr_q + CNT_W'(1);
               src_d   = src_q + 32'd4;
               state_d = S_RD_GAP;
            end else if (to_q == TO_W'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               wptr_d  = '0;
               rptr_d  = '0;
               rem_d   = '0;
               to_d    = '0;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_RD_GAP: begin
            to_d = '0;
            if (wptr_q == chunk_q) begin
               wptr_d  = '0;
               state_d = S_WR_REQ;
            end else begin
               state_d = S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            if (wbm_ack_i) begin
               rptr_d  = rptr_q + CNT_W'(1);
               dst_d   = dst_q + 32'd4;
               state_d = S_WR_GAP;
            end else if (to_q == TO_W'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               wptr_d  = '0;
               rptr_d  = '0;
               rem_d   = '0;
               to_d    = '0;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_WR_GAP: begin
            to_d = '0;
            if (rptr_q < chunk_q) begin
               state_d = S_WR_REQ;
            end else begin
               rptr_d = '0;
               rem_d  = rem_q - LEN_W'(chunk_q);
               if (rem_d == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  chunk_d = chunk_of(rem_d);
                  state_d = S_RD_REQ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Bus outputs follow the next state so they are registered yet aligned with it.
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
      stb_d   = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
      we_d    = (state_d == S_WR_REQ);
      sel_d   = we_d ? 4'hF : 4'h0;
      adr_d   = adr_q;
      dat_d   = dat_q;
      if (state_d == S_RD_REQ) begin
         adr_d = src_d;
      end else if (state_d == S_WR_REQ) begin
         adr_d = dst_d;
         dat_d = mem_q[rptr_d[PTR_W-1:0]];
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         chunk_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         to_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 4'h0;
         adr_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         chunk_q <= chunk_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         to_q    <= to_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
      end
   end

   // Chunk buffer; contents need no reset since pointers gate every use.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we) mem_q[wptr_q[PTR_W-1:0]] <= wbm_dat_i;
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign wbm_cyc_o = stb_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

endmodule

// File: doc/exmem_copy_master.md
# exmem_copy_master

Wishbone initiator that copies a block of 32-bit words from one address range to another through the external-memory Wishbone slave (SDRAM controller path). It accepts a copy command on a valid/ready port, reads up to BUF_DEPTH words into an internal buffer, writes them back out, and repeats until the length is exhausted. It is the requesting end of the same single-outstanding, ack-terminated Wishbone protocol the exmem slave answers, including slow SDRAM read latency.

## Interface
- BUF_DEPTH, 8: words buffered per chunk; power of two, 2..64.
- LEN_W, 16: width of cmd_len in words.
- TIMEOUT, 255: max cycles stb may wait for ack before abort; 1..65535.
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
- cmd_src  in  32  source byte address; bits [1:0] ignored (treated 0).
- cmd_dst  in  32  destination byte address; bits [1:0] ignored.
- cmd_len  in  LEN_W  word count; 0 legal.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout abort.
- wbm_cyc_o, wbm_stb_o  out  1  bus request; always driven equal.
- wbm_we_o  out  1  1 = write, 0 = read.
- wbm_sel_o  out  4  4'hF on writes, 4'h0 on reads.
- wbm_adr_o  out  32  byte address of current word.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave ack; ignored while stb low.
- wbm_dat_i  in  32  read data; sampled only on ack with we=0.

## Operation
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP.
- IDLE: cmd_ready=1. On accept latch src, dst (bits [1:0] cleared), remaining=cmd_len. If cmd_len=0: pulse done next cycle, stay IDLE, no bus traffic. Else chunk=min(remaining, BUF_DEPTH), go RD_REQ.
- RD_REQ: stb=1, we=0, adr=src. On ack: buf[wptr]<=wbm_dat_i, wptr++, src+=4, go RD_GAP.
- RD_GAP: stb=0 one cycle. If wptr==chunk: wptr=0, go WR_REQ; else RD_REQ.
- WR_REQ: stb=1, we=1, sel=4'hF, adr=dst, dat=buf[rptr]. On ack: rptr++, dst+=4, go WR_GAP.
- WR_GAP: stb=0 one cycle. If rptr<chunk: WR_REQ. Else rptr=0, remaining-=chunk; remaining==0: done pulse, IDLE; else new chunk, RD_REQ.
- One transaction outstanding at all times; adr/we/sel/dat held stable while stb high.
- Address arithmetic 32-bit, wraps 0xFFFFFFFC -> 0x00000000 silently.
- Overlapping ranges: chunkwise forward copy (each chunk fully read before written); no other guarantee.
- Timeout: counter clears on every stb rise; increments each cycle stb=1 without ack. Reaching TIMEOUT: drop stb/cyc next edge, err pulse, IDLE; buffer pointers and remaining cleared; done not pulsed.
- Ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
- cmd_valid while busy: ignored (cmd_ready=0); not queued.
- Reset asserted mid-operation: immediately cyc/stb/we=0, state IDLE, all counters 0; bus cycle abandoned.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, err=0, cyc=stb=we=0, sel=0, adr=0, dat=0.
- Accept at edge N -> stb high in cycle N+1 with adr=src.
- Ack sampled at edge K -> stb low cycle K+1 (gap) -> next request stb high cycle K+2.
- Per word: (slave latency cycles) + 1 gap cycle, both read and write.
- Final write ack at edge K -> WR_GAP cycle K+1 -> done=1, busy=0, cmd_ready=1 in cycle K+2; new command acceptable at that edge.
- len=0 accepted at edge N -> done=1 in cycle N+1, busy stays 0.
- err asserts cycle after timeout detection, with busy=0, cmd_ready=1.

## Test plan
- Reset: hold wb_rst_i 3 cycles, release asynchronously mid-cycle -> all outputs at reset values, cmd_ready=1.
- Copy src=0x38000000, dst=0x38000100, len=3, slave ack 2 cycles after stb with data 0xA0+i -> 3 reads then 3 writes, writes carry 0xA0,0xA1,0xA2 to 0x..100/104/108, sel=4'hF, single done pulse.
- len=20, BUF_DEPTH=8 -> read/write chunks of 8,8,4 words; 40 transactions; every stb followed by exactly one low cycle.
- len=0 -> done next cycle, cyc never asserted.
- Slave never acks on 2nd read, TIMEOUT=255 -> stb drops after 255 cycles, err pulse, no writes, next command accepted normally.
- Assert reset during a write with stb high -> stb/cyc low asynchronously, busy=0; subsequent len=1 copy completes correctly.
